// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, flags illegal encodings and counts retirements.
module multicycle_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic             retire,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      EXEC_R  = 4'd3,
      WB_R    = 4'd4,
      ADDR    = 4'd5,
      MEM_RD  = 4'd6,
      WB_LW   = 4'd7,
      MEM_WR  = 4'd8,
      BRANCH  = 4'd9,
      JUMP    = 4'd10,
      ILLEGAL = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   state_t state, next_state;
   logic   funct_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr_count <= '0;
      end else begin
         state <= next_state;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      funct_ok = 1'b0;
      case (funct)
         6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
         default:                           funct_ok = 1'b0;
      endcase
   end

   // Outputs depend only on state, except the FETCH/MEM_WR strobes that must
   // wait for the memory handshake to complete.
   always_comb begin
      next_state    = IDLE;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'd0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = 2'd0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      illegal       = 1'b0;
      retire        = 1'b0;
      case (state)
         IDLE: next_state = run ? FETCH : IDLE;
         FETCH: begin
            mem_req    = 1'b1;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            alu_src_b  = 2'd1;
            next_state = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b = 2'd3;
            if (opcode == OP_RTYPE && funct_ok)
               next_state = EXEC_R;
            else if (opcode == OP_LW || opcode == OP_SW)
               next_state = ADDR;
            else if (opcode == OP_BEQ)
               next_state = BRANCH;
            else if (opcode == OP_J)
               next_state = JUMP;
            else
               next_state = ILLEGAL;
         end
         EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'd2;
            next_state = WB_R;
         end
         WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
         end
         ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_req    = 1'b1;
            i_or_d     = 1'b1;
            next_state = mem_ready ? WB_LW : MEM_RD;
         end
         WB_LW: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         MEM_WR: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            i_or_d     = 1'b1;
            retire     = mem_ready;
            next_state = mem_ready ? IDLE : MEM_WR;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'd1;
            pc_write_cond = 1'b1;
            pc_src        = 2'd1;
            retire        = 1'b1;
         end
         JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            retire   = 1'b1;
         end
         ILLEGAL: illegal = 1'b1;
         default: next_state = IDLE;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table for the
// instruction sequences, plus hand-written reset-abort and counter-wrap cases.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             run;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             mem_ready;
   logic             mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
   logic [1:0]       pc_src;
   logic             alu_src_a;
   logic [1:0]       alu_src_b, alu_op;
   logic             reg_write, reg_dst, mem_to_reg, illegal, retire;
   logic [CNT_W-1:0] instr_count;
   logic [3:0]       state_o;
   logic [17:0]      act_ctrl;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .retire(retire), .instr_count(instr_count), .state_o(state_o)
   );

   always #5 clk = ~clk;

   assign act_ctrl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                      alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                      illegal, retire};

   // Field order: req,we,iord,irw,pcw,pcwc,pcsrc[2],srca,srcb[2],aluop[2],rw,rdst,m2r,ill,ret
   localparam logic [17:0] E_IDLE    = 18'd0;
   localparam logic [17:0] E_FETCH_W = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,1'b0,2'd1,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd3,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_WBR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b1};
   localparam logic [17:0] E_ADDR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,2'd2,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_MEMRD   = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_WBLW    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b1};
   localparam logic [17:0] E_MEMWR_W = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [17:0] E_MEMWR_R = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1};
   localparam logic [17:0] E_BR      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,1'b1,2'd0,2'd1,1'b0,1'b0,1'b0,1'b0,1'b1};
   localparam logic [17:0] E_J       = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1};
   localparam logic [17:0] E_ILL     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0};

   typedef struct {
      logic        run;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic        mem_ready;
      logic [3:0]  exp_state;
      logic [17:0] exp_ctrl;
      int          exp_count;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic r, input logic [5:0] op, input logic [5:0] f,
                         input logic mr, input logic [3:0] st, input logic [17:0] c,
                         input int cnt);
      vec_t v;
      v.run = r; v.opcode = op; v.funct = f; v.mem_ready = mr;
      v.exp_state = st; v.exp_ctrl = c; v.exp_count = cnt;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] f,
                                input logic mr);
      run = r; opcode = op; funct = f; mem_ready = mr;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One R-type instruction from IDLE through WB_R; returns at the following IDLE.
   task automatic runRType();
      int n = 0;
      applyStimulus(1'b1, 6'h00, 6'h20, 1'b1);
      do begin
         @(negedge clk);
         n++;
      end while (state_o != 4'd4 && n < 20);
      checks++;
      if (n >= 20) begin
         errors++;
         $display("[TB] FAIL rtype_timeout: got state %0d, expected 4 within 20 cycles", state_o);
      end
      @(negedge clk);
   endtask

   initial begin
      // Vector i is applied at a falling edge and checked 1 ns later.
      addVec(1,6'h00,6'h20,1, 0, E_IDLE,    0);
      addVec(1,6'h00,6'h20,1, 1, E_FETCH_R, 0);
      addVec(1,6'h00,6'h20,1, 2, E_DECODE,  0);
      addVec(1,6'h00,6'h20,1, 3, E_EXEC,    0);
      addVec(1,6'h00,6'h20,1, 4, E_WBR,     0);
      addVec(1,6'h2B,6'h00,1, 0, E_IDLE,    1);
      addVec(1,6'h2B,6'h00,0, 1, E_FETCH_W, 1);
      addVec(1,6'h2B,6'h00,1, 1, E_FETCH_R, 1);
      addVec(1,6'h2B,6'h00,1, 2, E_DECODE,  1);
      addVec(1,6'h2B,6'h00,1, 5, E_ADDR,    1);
      addVec(1,6'h2B,6'h00,0, 8, E_MEMWR_W, 1);
      addVec(1,6'h2B,6'h00,1, 8, E_MEMWR_R, 1);
      addVec(1,6'h04,6'h00,1, 0, E_IDLE,    2);
      addVec(1,6'h04,6'h00,1, 1, E_FETCH_R, 2);
      addVec(1,6'h04,6'h00,1, 2, E_DECODE,  2);
      addVec(1,6'h04,6'h00,1, 9, E_BR,      2);
      addVec(1,6'h02,6'h00,1, 0, E_IDLE,    3);
      addVec(1,6'h02,6'h00,1, 1, E_FETCH_R, 3);
      addVec(1,6'h02,6'h00,1, 2, E_DECODE,  3);
      addVec(1,6'h02,6'h00,1, 10, E_J,      3);
      addVec(1,6'h3F,6'h20,1, 0, E_IDLE,    4);
      addVec(1,6'h3F,6'h20,1, 1, E_FETCH_R, 4);
      addVec(1,6'h3F,6'h20,1, 2, E_DECODE,  4);
      addVec(1,6'h3F,6'h20,1, 11, E_ILL,    4);
      addVec(1,6'h00,6'h08,1, 0, E_IDLE,    4);
      addVec(1,6'h00,6'h08,1, 1, E_FETCH_R, 4);
      addVec(1,6'h00,6'h08,1, 2, E_DECODE,  4);
      addVec(1,6'h00,6'h08,1, 11, E_ILL,    4);
      addVec(0,6'h00,6'h20,1, 0, E_IDLE,    4);
      addVec(0,6'h00,6'h20,1, 0, E_IDLE,    4);
      addVec(1,6'h23,6'h00,1, 0, E_IDLE,    4);
      addVec(0,6'h23,6'h00,1, 1, E_FETCH_R, 4);
      addVec(0,6'h23,6'h00,1, 2, E_DECODE,  4);
      addVec(0,6'h23,6'h00,1, 5, E_ADDR,    4);
      addVec(0,6'h23,6'h00,0, 6, E_MEMRD,   4);
      addVec(0,6'h23,6'h00,0, 6, E_MEMRD,   4);
      addVec(0,6'h23,6'h00,0, 6, E_MEMRD,   4);
      addVec(0,6'h23,6'h00,1, 6, E_MEMRD,   4);
      addVec(0,6'h23,6'h00,1, 7, E_WBLW,    4);
      addVec(0,6'h23,6'h00,1, 0, E_IDLE,    5);
      addVec(0,6'h23,6'h00,1, 0, E_IDLE,    5);

      rst_n = 1'b0;
      applyStimulus(1'b0, 6'h00, 6'h00, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("reset_state", int'(state_o), 0);
      checkOutput("reset_ctrl", int'(act_ctrl), int'(E_IDLE));
      checkOutput("reset_count", int'(instr_count), 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i].run, vecs[i].opcode, vecs[i].funct, vecs[i].mem_ready);
         #1;
         checkOutput($sformatf("v%0d_state", i), int'(state_o), int'(vecs[i].exp_state));
         checkOutput($sformatf("v%0d_ctrl", i), int'(act_ctrl), int'(vecs[i].exp_ctrl));
         checkOutput($sformatf("v%0d_count", i), int'(instr_count), vecs[i].exp_count);
      end

      // lw stalled in MEM_RD, then asynchronous reset mid-cycle.
      @(negedge clk);
      applyStimulus(1'b1, 6'h23, 6'h00, 1'b1);
      repeat (4) @(negedge clk);
      applyStimulus(1'b0, 6'h23, 6'h00, 1'b0);
      #1;
      checkOutput("pre_reset_memrd", int'(state_o), 6);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_state", int'(state_o), 0);
      checkOutput("async_rst_ctrl", int'(act_ctrl), int'(E_IDLE));
      checkOutput("async_rst_count", int'(instr_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Counter wraps 15 -> 0 on the sixteenth retirement.
      for (int k = 0; k < 15; k++) runRType();
      checkOutput("count_15", int'(instr_count), 15);
      runRType();
      applyStimulus(1'b0, 6'h00, 6'h20, 1'b1);
      #1;
      checkOutput("count_wrap", int'(instr_count), 0);
      @(negedge clk);
      #1;
      checkOutput("idle_hold_state", int'(state_o), 0);
      checkOutput("idle_hold_memreq", int'(mem_req), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
